config_buf_ctrl: RTL and testbench

- Write-side controller for the config menu tile buffer: the 40x23 grid of 8-bit tile indices that the config video pipeline reads every pixel.
- Shares the buffer's single write port between two requesters:
  - a bulk clear/fill engine;
  - a host cell-write port with valid/ready handshake, backed by a small FIFO.
- Writes are scheduled only inside the permitted write window, which is vertical blanking by default.
- Address mapping is identical to the video read side: addr = row*40 + col, where row*40 = (row<<5) + (row<<3).

---
 rtl/config_buf_ctrl_pkg.sv | 15 +
 rtl/config_buf_ctrl_if.sv | 21 ++
 rtl/config_buf_ctrl_fifo.sv | 49 ++++
 rtl/config_buf_ctrl.sv | 134 +++++++++++++
 tb/tb_config_buf_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/config_buf_ctrl_pkg.sv
// Shared types and constants for the config menu tile-buffer write controller.
package config_pkg;
    localparam int COLS      = 40;
    localparam int ROWS      = 23;
    localparam int NUM_CELLS = COLS * ROWS;
    localparam int H_ACTIVE  = 1280;
    localparam int V_ACTIVE  = 720;

    typedef enum logic {S_IDLE, S_CLEAR} ctrl_state_t;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } cell_wr_t;
endpackage

// File: rtl/config_buf_ctrl_if.sv
// Host cell-write handshake plus tile-buffer write port.
interface config_buf_ctrl_if;
    logic       wr_valid_in;
    logic       wr_ready_out;
    logic [5:0] wr_col_in;
    logic [4:0] wr_row_in;
    logic [7:0] wr_data_in;
    logic       wr_err_out;
    logic       buf_we_out;
    logic [9:0] buf_write_addr_out;
    logic [7:0] buf_write_data_out;

    modport ctrl (
        input  wr_valid_in, wr_col_in, wr_row_in, wr_data_in,
        output wr_ready_out, wr_err_out, buf_we_out, buf_write_addr_out, buf_write_data_out
    );
    modport tb (
        output wr_valid_in, wr_col_in, wr_row_in, wr_data_in,
        input  wr_ready_out, wr_err_out, buf_we_out, buf_write_addr_out, buf_write_data_out
    );
endinterface

// File: rtl/config_buf_ctrl_fifo.sv
// Small synchronous FIFO holding pre-mapped host cell writes.
module config_wr_fifo
    import config_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     push_i,
    input  cell_wr_t din_i,
    input  logic     pop_i,
    output cell_wr_t dout_o,
    output logic     full_o,
    output logic     empty_o
);
    localparam int AW = $clog2(DEPTH);

    cell_wr_t [DEPTH-1:0] mem_q;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end
endmodule

// File: rtl/config_buf_ctrl.sv
// Arbitrates the tile buffer write port between the bulk clear engine and host writes.
module config_buf_ctrl #(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int COLS       = 40,
    parameter int ROWS       = 23,
    parameter int FIFO_DEPTH = 4,
    parameter bit BLANK_ONLY = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        clear_start_in,
    input  logic [7:0]  clear_value_in,
    output logic        clear_busy_out,
    output logic        clear_done_out,
    config_buf_ctrl_if.ctrl bus
);
    import config_pkg::*;

    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [5:0] COLS6 = 6'(COLS);
    localparam logic [4:0] ROWS5 = 5'(ROWS);
    localparam logic [9:0] NCELL = 10'(COLS * ROWS);

    ctrl_state_t state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [7:0]  val_q, val_d;
    logic        we_q, we_d, busy_q, busy_d, done_q, done_d, err_q;
    logic [9:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    logic       win, hs, in_range, pop, full, empty;
    logic [9:0] row10;
    cell_wr_t   push_cell, head;

    // Horizontal position does not gate writes; the whole blanking interval is usable.
    logic unused_hcount;
    assign unused_hcount = ^hcount_in;

    assign win      = !BLANK_ONLY || (vcount_in >= V_ACT);
    assign hs       = bus.wr_valid_in && !full;
    assign in_range = (bus.wr_col_in < COLS6) && (bus.wr_row_in < ROWS5);
    assign row10    = {5'b0, bus.wr_row_in};
    assign push_cell.addr = (row10 << 5) + (row10 << 3) + {4'b0, bus.wr_col_in};
    assign push_cell.data = bus.wr_data_in;

    config_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push_i  (hs && in_range),
        .din_i   (push_cell),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_start_in) begin
                    val_d   = clear_value_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CLEAR;
                end else if (win && !empty) begin
                    pop    = 1'b1;
                    we_d   = 1'b1;
                    addr_d = head.addr;
                    data_d = head.data;
                end
            end
            S_CLEAR: begin
                // Counter reaching NCELL means the last cell went out the previous cycle.
                if (cnt_q == NCELL) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    busy_d = 1'b1;
                    if (win) begin
                        we_d   = 1'b1;
                        addr_d = cnt_q;
                        data_d = val_q;
                        cnt_d  = cnt_q + 10'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= hs && !in_range;
        end
    end

    assign clear_busy_out         = busy_q;
    assign clear_done_out         = done_q;
    assign bus.wr_ready_out       = !full;
    assign bus.wr_err_out         = err_q;
    assign bus.buf_we_out         = we_q;
    assign bus.buf_write_addr_out = addr_q;
    assign bus.buf_write_data_out = data_q;
endmodule

// File: tb/tb_config_buf_ctrl.sv
// Directed bench for config_buf_ctrl: host writes, FIFO backpressure, clears, errors, reset.
module tb_config_buf_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        clr_start = 1'b0;
    logic [7:0]  clr_val = '0;
    logic        busy, done;
    int          n_run = 0, n_fail = 0;

    config_buf_ctrl_if ifc ();

    config_buf_ctrl dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .hcount_in      (hcount),
        .vcount_in      (vcount),
        .clear_start_in (clr_start),
        .clear_value_in (clr_val),
        .clear_busy_out (busy),
        .clear_done_out (done),
        .bus            (ifc.ctrl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host(input logic [5:0] c, input logic [4:0] r, input logic [7:0] d);
        ifc.wr_valid_in = 1'b1;
        ifc.wr_col_in   = c;
        ifc.wr_row_in   = r;
        ifc.wr_data_in  = d;
        tick();
        ifc.wr_valid_in = 1'b0;
    endtask

    logic [9:0] exp_addr [4] = '{10'd0, 10'd39, 10'd880, 10'd919};
    logic [7:0] exp_data [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [5:0] q_col    [4] = '{6'd0, 6'd39, 6'd0, 6'd39};
    logic [4:0] q_row    [4] = '{5'd0, 5'd0, 5'd22, 5'd22};

    initial begin
        int bad, nwr, seen_done, vc_edge;
        ifc.wr_valid_in = 1'b0;
        ifc.wr_col_in   = '0;
        ifc.wr_row_in   = '0;
        ifc.wr_data_in  = '0;

        // Reset state
        #12;
        chk("rst_we",   ifc.buf_we_out, 0);
        chk("rst_addr", ifc.buf_write_addr_out, 0);
        chk("rst_data", ifc.buf_write_data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err",  ifc.wr_err_out, 0);
        rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", ifc.wr_ready_out, 1);

        // Single host write inside blanking
        vcount = 10'd725;
        host(6'd3, 5'd2, 8'h41);
        chk("hw_lat0_we", ifc.buf_we_out, 0);
        tick();
        chk("hw_we",   ifc.buf_we_out, 1);
        chk("hw_addr", ifc.buf_write_addr_out, 83);
        chk("hw_data", ifc.buf_write_data_out, 8'h41);
        tick();
        chk("hw_once", ifc.buf_we_out, 0);

        // Fill FIFO outside window, then drain
        vcount = 10'd100;
        for (int i = 0; i < 4; i++) begin
            chk("fill_rdy", ifc.wr_ready_out, 1);
            host(q_col[i], q_row[i], exp_data[i]);
        end
        chk("full_rdy", ifc.wr_ready_out, 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ifc.buf_we_out !== 1'b0) bad++;
        end
        chk("no_wr_outside_win", bad, 0);
        vcount = 10'd720;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_we",   ifc.buf_we_out, 1);
            chk("drain_addr", ifc.buf_write_addr_out, exp_addr[i]);
            chk("drain_data", ifc.buf_write_data_out, exp_data[i]);
            if (i == 0) chk("rdy_after_pop", ifc.wr_ready_out, 1);
        end
        tick();
        chk("drain_end", ifc.buf_we_out, 0);

        // Full clear with window held open
        vcount = 10'd730;
        clr_start = 1'b1;
        clr_val = 8'h20;
        tick();
        clr_start = 1'b0;
        clr_val = 8'h00;
        chk("clr_busy0", busy, 1);
        chk("clr_we0", ifc.buf_we_out, 0);
        bad = 0;
        for (int i = 0; i < 920; i++) begin
            tick();
            if (ifc.buf_we_out !== 1'b1 || ifc.buf_write_addr_out !== 10'(i) ||
                ifc.buf_write_data_out !== 8'h20 || busy !== 1'b1 || done !== 1'b0) bad++;
        end
        chk("clr_seq_bad", bad, 0);
        tick();
        chk("clr_done", done, 1);
        chk("clr_busy_end", busy, 0);
        chk("clr_we_end", ifc.buf_we_out, 0);
        tick();
        chk("clr_done_once", done, 0);

        // Clear with window toggling in 100-cycle blocks
        vcount = 10'd719;
        clr_start = 1'b1;
        clr_val = 8'h5A;
        tick();
        clr_start = 1'b0;
        bad = 0; nwr = 0; seen_done = 0;
        for (int cyc = 0; cyc < 2200 && seen_done == 0; cyc++) begin
            vcount = ((cyc / 100) % 2 == 0) ? 10'd719 : 10'd720;
            vc_edge = int'(vcount);
            tick();
            if (done === 1'b1) seen_done = 1;
            else if (ifc.buf_we_out === 1'b1) begin
                if (vc_edge < 720 || ifc.buf_write_addr_out !== 10'(nwr) ||
                    ifc.buf_write_data_out !== 8'h5A) bad++;
                nwr++;
            end
        end
        chk("tog_done_seen", seen_done, 1);
        chk("tog_bad", bad, 0);
        chk("tog_count", nwr, 920);

        // Out-of-range host writes
        vcount = 10'd725;
        tick();
        host(6'd40, 5'd0, 8'h99);
        chk("err_col", ifc.wr_err_out, 1);
        chk("err_col_we", ifc.buf_we_out, 0);
        tick();
        chk("err_col_once", ifc.wr_err_out, 0);
        chk("err_col_we2", ifc.buf_we_out, 0);
        host(6'd0, 5'd23, 8'h98);
        chk("err_row", ifc.wr_err_out, 1);
        tick();
        chk("err_row_once", ifc.wr_err_out, 0);
        chk("err_row_we", ifc.buf_we_out, 0);

        // Reset in the middle of a clear with a host write queued
        vcount = 10'd730;
        clr_start = 1'b1;
        clr_val = 8'h33;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        host(6'd5, 5'd1, 8'h77);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_we",   ifc.buf_we_out, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_addr", ifc.buf_write_addr_out, 0);
        tick();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifc.buf_we_out !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("mrst_quiet", bad, 0);
        chk("mrst_rdy", ifc.wr_ready_out, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
